// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states and opcode helpers shared by the ALU files
package alu_seq_pkg;
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SLL = 6'b000000;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SRA = 6'b000011;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
  function automatic logic is_shift(input logic [5:0] op);
    return op == OP_SLL || op == OP_SRL || op == OP_SRA;
  endfunction
endpackage

// File: rtl/alu_seq_comb.sv
// alu_seq_comb: single-cycle add/sub/logic ops with carry, overflow and error flags
module alu_seq_comb
  import alu_seq_pkg::*;
#(
  parameter int N_BITS = 8
) (
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  input  logic [5:0]        op,
  output logic [N_BITS-1:0] result,
  output logic              carry,
  output logic              ovf,
  output logic              err
);
  logic [N_BITS:0] sum, dif;
  logic [N_BITS-1:0] bp;
  logic add, sub;
  always_comb begin
    add = op == OP_ADD;
    sub = op == OP_SUB;
    sum = {1'b0, a} + {1'b0, b};
    dif = {1'b0, a} - {1'b0, b};
    bp = sub ? -b : b;
    err = !(add || sub || op == OP_AND || op == OP_OR || op == OP_XOR || op == OP_NOR || is_shift(op));
    result = add ? sum[N_BITS-1:0] :
             sub ? dif[N_BITS-1:0] :
             op == OP_AND ? a & b :
             op == OP_OR  ? a | b :
             op == OP_XOR ? a ^ b :
             op == OP_NOR ? ~(a | b) : '0;
    carry = add ? sum[N_BITS] : sub & dif[N_BITS];
    ovf = (add | sub) & (a[N_BITS-1] == bp[N_BITS-1]) & (result[N_BITS-1] != a[N_BITS-1]);
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked registered ALU; single-cycle ops plus iterative 1-bit/cycle shifts
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int N_BITS = 8,
  parameter int N_OP = 6,
  localparam int SHW = $clog2(N_BITS)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [N_BITS-1:0] i_a,
  input  logic [N_BITS-1:0] i_b,
  input  logic [N_OP-1:0]   i_op,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [N_BITS-1:0] o_result,
  output logic              o_zero,
  output logic              o_carry,
  output logic              o_ovf,
  output logic              o_err
);
  state_t state, state_n;
  logic [N_BITS-1:0] res, c_res, a_res, sh_n;
  logic [SHW-1:0] cnt, s;
  logic [N_OP-1:0] op_r;
  logic c_carry, c_ovf, c_err, sh_out, zero, carry, ovf, err, acc, go_shift;
  alu_seq_comb #(.N_BITS(N_BITS)) u_comb (
    .a(i_a), .b(i_b), .op(i_op), .result(c_res), .carry(c_carry), .ovf(c_ovf), .err(c_err)
  );
  always_comb begin
    s = i_b[SHW-1:0];
    acc = i_valid & o_ready;
    go_shift = is_shift(i_op) && s != '0;
    a_res = is_shift(i_op) ? i_a : c_res;
    sh_n = op_r == OP_SLL ? {res[N_BITS-2:0], 1'b0} : {op_r == OP_SRA & res[N_BITS-1], res[N_BITS-1:1]};
    sh_out = op_r == OP_SLL ? res[N_BITS-1] : res[0];
  end
  always_ff @(posedge i_clk) state <= i_reset ? ST_IDLE : state_n;
  always_comb
    state_n = state == ST_IDLE  ? (acc ? (go_shift ? ST_SHIFT : ST_DONE) : ST_IDLE) :
              state == ST_SHIFT ? (cnt == SHW'(1) ? ST_DONE : ST_SHIFT) :
              state == ST_DONE  ? (i_ready ? ST_IDLE : ST_DONE) : ST_IDLE;
  always_comb begin
    o_ready = state == ST_IDLE;
    o_valid = state == ST_DONE;
  end
  // flags only move on the edge that enters DONE; res walks through the shift meanwhile
  always_ff @(posedge i_clk)
    if (i_reset) begin
      {res, cnt, op_r} <= '0;
      {zero, carry, ovf, err} <= '0;
    end else if (acc) begin
      op_r <= i_op;
      cnt <= s;
      res <= a_res;
      if (!go_shift) begin
        zero <= a_res == '0;
        carry <= c_carry;
        ovf <= c_ovf;
        err <= c_err;
      end
    end else if (state == ST_SHIFT) begin
      res <= sh_n;
      cnt <= cnt - 1'b1;
      if (cnt == SHW'(1)) begin
        zero <= sh_n == '0;
        carry <= sh_out;
        ovf <= 1'b0;
        err <= 1'b0;
      end
    end
  assign o_result = res;
  assign o_zero = zero;
  assign o_carry = carry;
  assign o_ovf = ovf;
  assign o_err = err;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors into a scoreboard queue; a negedge monitor pops and checks results
module tb_alu_seq;
  import alu_seq_pkg::*;
  typedef struct {
    logic [7:0] r;
    logic z, c, v, e;
    int lat;
    int cyc;
  } exp_t;
  logic clk = 0, rst = 1, i_valid = 0, o_ready, o_valid, i_ready = 1;
  logic [7:0] i_a = 0, i_b = 0, o_result;
  logic [5:0] i_op = 0;
  logic o_zero, o_carry, o_ovf, o_err;
  int checks = 0, errors = 0, cyc = 0;
  exp_t q[$];
  bit seen = 0;
  logic [11:0] snap;
  alu_seq #(.N_BITS(8), .N_OP(6)) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .o_ready(o_ready), .i_a(i_a), .i_b(i_b),
    .i_op(i_op), .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_zero(o_zero),
    .o_carry(o_carry), .o_ovf(o_ovf), .o_err(o_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst) seen = 0;
    else if (o_valid) begin
      if (q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        if (!seen) begin
          seen = 1;
          chk("latency", cyc - q[0].cyc, q[0].lat);
          snap = {o_result, o_zero, o_carry, o_ovf, o_err};
        end else chk("hold", {o_result, o_zero, o_carry, o_ovf, o_err}, snap);
        if (i_ready) begin
          exp_t e;
          e = q.pop_front();
          seen = 0;
          chk("result", o_result, e.r);
          chk("zero", o_zero, e.z);
          chk("carry", o_carry, e.c);
          chk("ovf", o_ovf, e.v);
          chk("err", o_err, e.e);
        end
      end
    end
  end
  task automatic issue(input logic [7:0] a, b, input logic [5:0] op, input logic [7:0] r,
                       input logic z, c, v, e, input int lat, input bit push);
    int t = 0;
    while (!o_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!o_ready) chk("ready_timeout", 0, 1);
    i_a = a; i_b = b; i_op = op; i_valid = 1;
    if (push) q.push_back('{r: r, z: z, c: c, v: v, e: e, lat: lat, cyc: cyc});
    @(posedge clk); #1;
    i_valid = 0;
  endtask
  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_result", o_result, 0);
    chk("rst_flags", {o_zero, o_carry, o_ovf, o_err}, 0);
    rst = 0;
    issue(8'h90, 8'h01, OP_ADD, 8'h91, 0, 0, 0, 0, 1, 1);
    issue(8'h7F, 8'h01, OP_ADD, 8'h80, 0, 0, 1, 0, 1, 1);
    issue(8'hFF, 8'h01, OP_ADD, 8'h00, 1, 1, 0, 0, 1, 1);
    issue(8'h01, 8'h02, OP_SUB, 8'hFF, 0, 1, 0, 0, 1, 1);
    issue(8'h80, 8'h01, OP_SUB, 8'h7F, 0, 0, 1, 0, 1, 1);
    issue(8'h90, 8'h01, OP_NOR, 8'h6E, 0, 0, 0, 0, 1, 1);
    issue(8'hF0, 8'h3C, OP_AND, 8'h30, 0, 0, 0, 0, 1, 1);
    issue(8'hF0, 8'h0F, OP_OR,  8'hFF, 0, 0, 0, 0, 1, 1);
    issue(8'hFF, 8'hFF, OP_XOR, 8'h00, 1, 0, 0, 0, 1, 1);
    issue(8'h90, 8'h03, OP_SRA, 8'hF2, 0, 0, 0, 0, 4, 1);
    issue(8'h91, 8'h01, OP_SRL, 8'h48, 0, 1, 0, 0, 2, 1);
    issue(8'h90, 8'h01, OP_SLL, 8'h20, 0, 1, 0, 0, 2, 1);
    issue(8'h55, 8'h08, OP_SLL, 8'h55, 0, 0, 0, 0, 1, 1);
    issue(8'h01, 8'h07, OP_SLL, 8'h80, 0, 0, 0, 0, 8, 1);
    issue(8'h80, 8'h07, OP_SRL, 8'h01, 0, 0, 0, 0, 8, 1);
    issue(8'h12, 8'h34, 6'b111111, 8'h00, 1, 0, 0, 1, 1, 1);
    drain();
    i_ready = 0;
    issue(8'h7F, 8'h7F, OP_ADD, 8'hFE, 0, 0, 1, 0, 1, 1);
    repeat (5) begin
      i_valid = 1; i_a = 8'h01; i_b = 8'h01; i_op = OP_ADD;
      chk("bp_ready", o_ready, 0);
      @(posedge clk); #1;
    end
    i_valid = 0;
    i_ready = 1;
    drain();
    issue(8'h91, 8'h07, OP_SRL, 8'h00, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    chk("abort_valid", o_valid, 0);
    chk("abort_ready", o_ready, 1);
    chk("abort_result", o_result, 0);
    rst = 0;
    issue(8'h10, 8'h20, OP_ADD, 8'h30, 0, 0, 0, 0, 1, 1);
    drain();
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
